vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_timing.sv | 28 ++
 rtl/vga_sync_edge.sv | 32 +++
 rtl/vga_capture.sv | 162 ++++++++++++++++
 tb/tb_vga_capture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing.sv
// Shared 640x480 timing constants and capture FSM encoding, used by
// vga_capture and vga_controller.
package vga_timing;

    localparam int HACTIVE    = 640;
    localparam int HSYNCPULSE = 96;
    localparam int HBACKPORCH = 48;
    localparam int HTOTAL     = 800;
    localparam int VACTIVE    = 480;
    localparam int VSYNCPULSE = 2;
    localparam int VBACKPORCH = 33;
    localparam int VTOTAL     = 525;

    localparam int COUNT_W = 10;
    localparam int ADDR_W  = 19;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEEK    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Half-open window test [lo, hi) on a line/pixel counter.
    function automatic logic in_window(input logic [COUNT_W-1:0] cnt,
                                       input logic [COUNT_W-1:0] lo,
                                       input logic [COUNT_W-1:0] hi);
        in_window = (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// One sync line: S1 input register plus falling-edge detect against the
// previous S1 value. Both registers idle high so reset never fakes an edge.
module vga_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    output logic fall
);

    logic s1_q;
    logic s1_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        s1_d   = sync_in;
        prev_d = s1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~s1_q;

endmodule

// File: rtl/vga_capture.sv
// Locks onto an incoming VGA stream and writes each active pixel of a frame
// to a frame RAM in raster order; bad line timing aborts the frame.
module vga_capture
    import vga_timing::*;
#(
    parameter int hactive    = HACTIVE,
    parameter int hsyncpulse = HSYNCPULSE,
    parameter int hbackporch = HBACKPORCH,
    parameter int htotal     = HTOTAL,
    parameter int vactive    = VACTIVE,
    parameter int vsyncpulse = VSYNCPULSE,
    parameter int vbackporch = VBACKPORCH,
    parameter int vtotal     = VTOTAL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [2:0]  vga_rgb,
    input  logic        capture_enable,
    output logic        mem_wr_en,
    output logic [18:0] mem_address,
    output logic [2:0]  mem_data,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_error,
    output logic [1:0]  debug_state
);

    localparam int H_START_I = hsyncpulse + hbackporch;
    localparam int V_START_I = vsyncpulse + vbackporch;
    // The active window is clipped to the frame so odd parameter sets cannot
    // ask for pixels beyond the line or frame end.
    localparam int H_END_I = (H_START_I + hactive < htotal) ? H_START_I + hactive : htotal;
    localparam int V_END_I = (V_START_I + vactive < vtotal) ? V_START_I + vactive : vtotal;

    localparam logic [COUNT_W-1:0] H_START   = COUNT_W'(H_START_I);
    localparam logic [COUNT_W-1:0] H_END     = COUNT_W'(H_END_I);
    localparam logic [COUNT_W-1:0] V_START   = COUNT_W'(V_START_I);
    localparam logic [COUNT_W-1:0] V_END     = COUNT_W'(V_END_I);
    localparam logic [COUNT_W-1:0] H_LAST    = COUNT_W'(htotal - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(hactive * vactive - 1);

    logic hfall;
    logic vfall;

    vga_sync_edge u_hsync_edge (
        .clock   (clock),
        .reset   (reset),
        .sync_in (vga_hsync),
        .fall    (hfall)
    );

    vga_sync_edge u_vsync_edge (
        .clock   (clock),
        .reset   (reset),
        .sync_in (vga_vsync),
        .fall    (vfall)
    );

    logic [2:0]         rgb_s1_q,      rgb_s1_d;
    logic [COUNT_W-1:0] h_count_q,     h_count_d;
    logic [COUNT_W-1:0] v_count_q,     v_count_d;
    logic [1:0]         state_q,       state_d;
    logic               mem_wr_en_q,   mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [2:0]         mem_data_q,    mem_data_d;
    logic               frame_done_q,  frame_done_d;
    logic               sync_error_q,  sync_error_d;
    logic               active;
    logic               line_err;

    always_comb begin
        rgb_s1_d = vga_rgb;

        h_count_d = (h_count_q == '1) ? h_count_q : h_count_q + 1'b1;
        if (hfall) begin
            h_count_d = '0;
        end

        v_count_d = v_count_q;
        if (vfall) begin
            v_count_d = '0;
        end else if (hfall && (v_count_q != '1)) begin
            v_count_d = v_count_q + 1'b1;
        end

        active   = in_window(h_count_q, H_START, H_END) && in_window(v_count_q, V_START, V_END);
        // A complete frame leaves CAPTURE before the next vsync edge, so any
        // vsync edge seen while capturing means the frame came up short.
        line_err = (hfall && (h_count_q != H_LAST)) || vfall;

        state_d       = state_q;
        mem_wr_en_d   = 1'b0;
        mem_address_d = mem_wr_en_q ? mem_address_q + 1'b1 : mem_address_q;
        mem_data_d    = mem_data_q;
        frame_done_d  = 1'b0;
        sync_error_d  = sync_error_q;

        case (state_q)
            ST_IDLE: begin
                if (capture_enable) begin
                    state_d = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (vfall) begin
                    state_d       = ST_CAPTURE;
                    mem_address_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (mem_wr_en_q && (mem_address_q == LAST_ADDR)) begin
                    frame_done_d = 1'b1;
                    state_d      = capture_enable ? ST_SEEK : ST_IDLE;
                end else if (line_err) begin
                    sync_error_d = 1'b1;
                    state_d      = ST_SEEK;
                end else if (active) begin
                    mem_wr_en_d = 1'b1;
                    mem_data_d  = rgb_s1_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_s1_q      <= '0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            state_q       <= ST_IDLE;
            mem_wr_en_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            frame_done_q  <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            rgb_s1_q      <= rgb_s1_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            state_q       <= state_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            frame_done_q  <= frame_done_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign frame_done  = frame_done_q;
    assign locked      = (state_q == ST_CAPTURE);
    assign sync_error  = sync_error_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Drives scaled-down VGA frames through vga_capture and checks every write and
// frame_done pulse against a frame-level reference model.
module tb_vga_capture;

    localparam int HA   = 16;
    localparam int HS   = 4;
    localparam int HBP  = 3;
    localparam int HT   = 28;
    localparam int VA   = 6;
    localparam int VS   = 2;
    localparam int VBP  = 3;
    localparam int VT   = 12;
    localparam int NPIX = HA * VA;
    localparam int W    = 54;

    localparam int M_IDLE = 0;
    localparam int M_SEEK = 1;
    localparam int M_CAP  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic [2:0]  vga_rgb = 3'd0;
    logic        capture_enable = 1'b0;
    logic        mem_wr_en;
    logic [18:0] mem_address;
    logic [2:0]  mem_data;
    logic        frame_done;
    logic        locked;
    logic        sync_error;
    logic [1:0]  debug_state;

    vga_capture #(
        .hactive    (HA),
        .hsyncpulse (HS),
        .hbackporch (HBP),
        .htotal     (HT),
        .vactive    (VA),
        .vsyncpulse (VS),
        .vbackporch (VBP),
        .vtotal     (VT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_rgb        (vga_rgb),
        .capture_enable (capture_enable),
        .mem_wr_en      (mem_wr_en),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .frame_done     (frame_done),
        .locked         (locked),
        .sync_error     (sync_error),
        .debug_state    (debug_state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries: {cycle the write must appear, address, data}
    logic [W-1:0]  exp_q[$];
    logic [31:0]   done_q[$];

    int m_state = M_IDLE;
    int m_addr  = 0;
    bit m_err   = 1'b0;
    int prev_len = HT;
    int rst_at  = -1;
    int rst_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   64'(mem_wr_en),   64'd0);
        check({tag, "_address"}, 64'(mem_address), 64'd0);
        check({tag, "_data"},    64'(mem_data),    64'd0);
        check({tag, "_done"},    64'(frame_done),  64'd0);
        check({tag, "_locked"},  64'(locked),      64'd0);
        check({tag, "_sync_err"},64'(sync_error),  64'd0);
        check({tag, "_state"},   64'(debug_state), 64'(M_IDLE));
    endtask

    task automatic check_end(input string tag);
        check({tag, "_state"},    64'(debug_state), 64'(m_state));
        check({tag, "_sync_err"}, 64'(sync_error),  64'(m_err));
        check({tag, "_locked"},   64'(locked),      64'(m_state == M_CAP));
        check({tag, "_wr_left"},  64'(exp_q.size()), 64'd0);
        check({tag, "_done_left"},64'(done_q.size()), 64'd0);
    endtask

    // Reference model, fed with the position of the pixel just driven.
    task automatic model_cycle(input int l, input int p, input int len);
        logic [W-1:0] last;
        if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 1) check_reset_outputs("mid_reset");
            if (rst_cnt == 0) reset = 1'b0;
        end else if (rst_at >= 0 && m_state == M_CAP && m_addr == rst_at) begin
            reset = 1'b1;
            capture_enable = 1'b0;
            // Writes that would land on or after the reset edge never happen.
            while (exp_q.size() > 0) begin
                last = exp_q[exp_q.size()-1];
                if (int'(last[W-1:22]) > cyc) void'(exp_q.pop_back());
                else break;
            end
            m_state = M_IDLE;
            m_addr  = 0;
            m_err   = 1'b0;
            rst_at  = -1;
            rst_cnt = 3;
        end else begin
            if (p == 0) begin
                if (m_state == M_CAP && (l == 0 || prev_len != HT)) begin
                    m_err   = 1'b1;
                    m_state = M_SEEK;
                end else if (m_state == M_SEEK && l == 0) begin
                    m_state = M_CAP;
                    m_addr  = 0;
                end
            end
            if (m_state == M_CAP && l >= VS + VBP && l < VS + VBP + VA &&
                p >= HS + HBP + 1 && p < HS + HBP + HA + 1) begin
                exp_q.push_back({32'(cyc + 2), 19'(m_addr), vga_rgb});
                m_addr++;
                if (m_addr == NPIX) begin
                    done_q.push_back(32'(cyc + 3));
                    m_state = capture_enable ? M_SEEK : M_IDLE;
                end
            end
            if (m_state == M_IDLE && capture_enable) m_state = M_SEEK;
            if (l == VS + VBP + 1 && p == HS) check("locked_mid", 64'(locked), 64'(m_state == M_CAP));
            if (p == len - 1) prev_len = len;
        end
    endtask

    // Driver: one frame, optional short line and enable changes at line starts
    task automatic drive_frame(input int short_line, input int en_drop_line, input int en_rise_line);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                @(posedge clock);
                #1;
                if (p == 0 && l == en_drop_line) capture_enable = 1'b0;
                if (p == 0 && l == en_rise_line) capture_enable = 1'b1;
                vga_hsync = (p < HS) ? 1'b0 : 1'b1;
                vga_vsync = (l < VS) ? 1'b0 : 1'b1;
                vga_rgb   = 3'($urandom_range(0, 7));
                model_cycle(l, p, len);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or done
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: address=%0d data=%0d expected no write (cycle %0d)",
                         mem_address, mem_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("write", 64'({32'(cyc), mem_address, mem_data}), 64'(e));
            end
        end
        if (frame_done === 1'b1) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: frame_done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                check("frame_done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        capture_enable = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (m_state == M_IDLE && capture_enable) m_state = M_SEEK;
        end

        drive_frame(-1, -1, -1);
        check_end("full_frame");
        drive_frame(7, -1, -1);
        check_end("short_line");
        drive_frame(-1, -1, -1);
        check_end("after_error");
        drive_frame(-1, 7, -1);
        check_end("enable_drop");
        drive_frame(-1, -1, -1);
        check_end("idle_frame");
        drive_frame(-1, -1, 6);
        check_end("enable_mid");
        rst_at = $urandom_range(20, 60);
        drive_frame(-1, -1, -1);
        check_end("reset_frame");
        drive_frame(-1, -1, 2);
        check_end("rearm");
        drive_frame(-1, -1, -1);
        check_end("final_frame");

        repeat (5) @(posedge clock);
        #1;
        check("drain_writes", 64'(exp_q.size()), 64'd0);
        check("drain_done",   64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
